// File: rtl/mbist_fail_log_if.sv
// Bus between the MBIST subsystem/consumer and the fail log.
// The master drives run control, fail reports and pops; the slave returns log status.
interface mbist_fail_log_if #(
  parameter int ADDR = 4
);
  logic            start;
  logic            fail;
  logic [ADDR-1:0] fail_addr;
  logic            done;
  logic            pop;
  logic            log_valid;
  logic [ADDR-1:0] log_addr;
  logic [ADDR:0]   fail_count;
  logic            overflow;
  logic            log_done;
  logic            repairable;

  modport master (
    output start, fail, fail_addr, done, pop,
    input  log_valid, log_addr, fail_count, overflow, log_done, repairable
  );

  modport slave (
    input  start, fail, fail_addr, done, pop,
    output log_valid, log_addr, fail_count, overflow, log_done, repairable
  );
endinterface

// File: rtl/mbist_fail_log.sv
// MBIST fail log: captures each distinct failing address of a run into a small FIFO,
// counts unique failures, flags overflow and reports repairability against SPARES rows.
module mbist_fail_log #(
  parameter int ADDR   = 4,
  parameter int DEPTH  = 4,
  parameter int SPARES = 2
) (
  input logic             clk,
  input logic             rst,
  mbist_fail_log_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = ADDR + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR{1'b0}}};

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t state;
  state_t state_next;
  logic   clear;
  logic   capture_en;

  logic [ADDR-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [CNT_W-1:0] fail_count;
  logic             overflow;
  logic             prev_fail;
  logic [ADDR-1:0]  prev_addr;

  logic             empty;
  logic             full;
  logic             event_hit;
  logic             dup;
  logic             unique_evt;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [DEPTH-1:0] hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // start re-arms and clears from any state; capture is blocked on the clearing edge
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    capture_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ARMED;
          clear      = 1'b1;
        end
      end
      ARMED: begin
        if (bus.start) begin
          clear = 1'b1;
        end else begin
          capture_en = 1'b1;
          if (bus.done) state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = ARMED;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // An entry takes part in duplicate filtering only while it lies between head and tail
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [IDX_W-1:0] off;
    assign off    = IDX_W'(i) - rd_ptr[IDX_W-1:0];
    assign hit[i] = ({1'b0, off} < count) && (mem[i] == bus.fail_addr);
  end

  assign dup        = |hit;
  assign event_hit  = capture_en && bus.fail &&
                      (!prev_fail || (bus.fail_addr != prev_addr));
  assign unique_evt = event_hit && !dup;
  assign do_pop     = bus.pop && !empty;
  assign do_push    = unique_evt && (!full || do_pop);
  assign drop       = unique_evt && full && !do_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
      prev_fail  <= 1'b0;
      prev_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
      prev_fail  <= 1'b0;
      prev_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prev_fail <= bus.fail;
      prev_addr <= bus.fail_addr;
      if (do_push) begin
        mem[wr_ptr[IDX_W-1:0]] <= bus.fail_addr;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (unique_evt && (fail_count != MAX_CNT)) fail_count <= fail_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign bus.log_valid  = !empty;
  assign bus.log_addr   = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
  assign bus.fail_count = fail_count;
  assign bus.overflow   = overflow;
  assign bus.log_done   = (state == DONE);
  assign bus.repairable = (state == DONE) && !overflow &&
                          (fail_count <= CNT_W'(SPARES));
endmodule

// File: tb/tb_mbist_fail_log.sv
// Directed bench for mbist_fail_log: expected log entries go into a queue when a
// unique fail is driven and are popped against log_addr when the log is drained.
module tb_mbist_fail_log;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [3:0] exp_q [$];

  mbist_fail_log_if #(.ADDR(4)) bus ();

  mbist_fail_log #(
    .ADDR   (4),
    .DEPTH  (4),
    .SPARES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [31:0] cnt, input logic ovf,
                              input logic ldone, input logic rep);
    check_output({tag, "_count"}, 32'(bus.fail_count), cnt);
    check_output({tag, "_ovf"},   32'(bus.overflow),   32'(ovf));
    check_output({tag, "_done"},  32'(bus.log_done),   32'(ldone));
    check_output({tag, "_rep"},   32'(bus.repairable), 32'(rep));
  endtask

  task automatic run_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  // One-cycle fail pulse followed by a low cycle; stored marks a unique entry that fits
  task automatic fail_pulse(input logic [3:0] a, input bit stored);
    bus.fail      = 1'b1;
    bus.fail_addr = a;
    if (stored) exp_q.push_back(a);
    tick();
    bus.fail = 1'b0;
    tick();
  endtask

  task automatic compare_head(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: observed scoreboard empty expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_output({tag, "_valid"}, 32'(bus.log_valid), 32'd1);
      check_output({tag, "_addr"},  32'(bus.log_addr),  32'(e));
    end
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      compare_head(tag);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
    end
    check_output({tag, "_empty"}, 32'(bus.log_valid), 32'd0);
    check_output({tag, "_zero"},  32'(bus.log_addr),  32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.fail   = 1'b0;
    bus.fail_addr = 4'd0;
    bus.done   = 1'b0;
    bus.pop    = 1'b0;

    // Power-on reset
    #2 rst = 1'b0;
    #2;
    check_output("rst_valid", 32'(bus.log_valid), 32'd0);
    check_output("rst_addr",  32'(bus.log_addr),  32'd0);
    check_status("rst", 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset in the middle of a capture with fail still high
    run_start();
    bus.fail      = 1'b1;
    bus.fail_addr = 4'd5;
    tick();
    check_output("pre_rst_valid", 32'(bus.log_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("async_valid", 32'(bus.log_valid), 32'd0);
    check_output("async_count", 32'(bus.fail_count), 32'd0);
    tick();
    rst = 1'b1;
    bus.fail = 1'b0;
    tick();
    fail_pulse(4'd2, 1'b0);
    fail_pulse(4'd9, 1'b0);
    check_output("idle_ignore_valid", 32'(bus.log_valid), 32'd0);
    check_output("idle_ignore_count", 32'(bus.fail_count), 32'd0);

    // Addresses 3, 7, 3 with a duplicate
    run_start();
    fail_pulse(4'd3, 1'b1);
    fail_pulse(4'd7, 1'b1);
    fail_pulse(4'd3, 1'b0);
    check_output("dup_done_before", 32'(bus.log_done), 32'd0);
    run_done();
    check_status("dup", 2, 1'b0, 1'b1, 1'b1);
    drain("dup", 2);

    // fail held high: one event per address change
    run_start();
    bus.fail      = 1'b1;
    bus.fail_addr = 4'd5;
    exp_q.push_back(4'd5);
    repeat (5) tick();
    bus.fail_addr = 4'd6;
    exp_q.push_back(4'd6);
    tick();
    bus.fail = 1'b0;
    tick();
    check_output("held_count", 32'(bus.fail_count), 32'd2);
    run_done();
    drain("held", 2);

    // Overflow: five unique fails into four entries
    run_start();
    fail_pulse(4'd1, 1'b1);
    fail_pulse(4'd2, 1'b1);
    fail_pulse(4'd3, 1'b1);
    fail_pulse(4'd4, 1'b1);
    fail_pulse(4'd9, 1'b0);
    check_output("ovf_mid", 32'(bus.overflow), 32'd1);
    run_done();
    check_status("ovf", 5, 1'b1, 1'b1, 1'b0);
    drain("ovf", 4);

    // Same sequence with a pop alongside the fifth fail: no overflow
    run_start();
    fail_pulse(4'd1, 1'b1);
    fail_pulse(4'd2, 1'b1);
    fail_pulse(4'd3, 1'b1);
    fail_pulse(4'd4, 1'b1);
    compare_head("pp_head");
    bus.fail      = 1'b1;
    bus.fail_addr = 4'd9;
    bus.pop       = 1'b1;
    exp_q.push_back(4'd9);
    tick();
    bus.fail = 1'b0;
    bus.pop  = 1'b0;
    tick();
    run_done();
    check_status("pp", 5, 1'b0, 1'b1, 1'b0);
    drain("pp", 4);

    // Saturation: 17 unique events, each popped before the next
    run_start();
    for (int i = 0; i < 17; i++) begin
      bus.fail      = 1'b1;
      bus.fail_addr = 4'(i % 16);
      exp_q.push_back(4'(i % 16));
      tick();
      bus.fail = 1'b0;
      compare_head("sat_head");
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      if (i == 14) check_output("sat_15", 32'(bus.fail_count), 32'd15);
    end
    check_output("sat_count", 32'(bus.fail_count), 32'd16);
    check_output("sat_ovf",   32'(bus.overflow),   32'd0);
    run_done();
    check_output("sat_rep",   32'(bus.repairable), 32'd0);

    // Restart from DONE, then a clean run
    run_start();
    check_output("restart_done",  32'(bus.log_done),   32'd0);
    check_output("restart_count", 32'(bus.fail_count), 32'd0);
    check_output("restart_valid", 32'(bus.log_valid),  32'd0);
    repeat (3) tick();
    run_done();
    check_status("clean", 0, 1'b0, 1'b1, 1'b1);
    fail_pulse(4'd8, 1'b0);
    check_output("done_ignore", 32'(bus.log_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
